// File: rtl/score_to_state_encoder_if.sv
// score_to_state_encoder_if: handshake bundle between a tile-value producer/consumer and the encoder
//   in_valid/in_value/in_ready    : value offered to the encoder (transfer on valid && ready)
//   out_valid/out_ready           : result handshake (transfer on valid && ready)
//   out_state/out_error           : encoded exponent and "not a tile value" flag
//   master modport = environment side, slave modport = encoder side
interface score_to_state_encoder_if;
    logic        in_valid;
    logic [15:0] in_value;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_state;
    logic        out_error;
    modport master (
        output in_valid, in_value, out_ready,
        input  in_ready, out_valid, out_state, out_error
    );
    modport slave (
        input  in_valid, in_value, out_ready,
        output in_ready, out_valid, out_state, out_error
    );
endinterface

// File: rtl/score_to_state_encoder.sv
// score_to_state_encoder: converts a tile value (0 or 2^k) to its exponent by scanning bits serially
//   clk    : clock, rising edge
//   rst    : synchronous reset, active low
//   io_bus : slave side of score_to_state_encoder_if (input handshake, result handshake, state/error)
module score_to_state_encoder (
    input  logic                           clk,
    input  logic                           rst,
    score_to_state_encoder_if.slave        io_bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t      r_state, w_next;
    logic [15:0] r_sreg, w_sreg;
    logic [3:0]  r_cnt, w_cnt;
    logic        r_out_valid, w_out_valid;
    logic [3:0]  r_out_state, w_out_state;
    logic        r_out_error, w_out_error;
    logic        w_reject;
    // Reaching the lowest set bit ends the scan: extra bits above it, bit 0 (value 1)
    // or bit 15 (value 32768) are not valid tile values.
    assign w_reject = (r_sreg[15:1] != 15'd0) || (r_cnt == 4'd0) || (r_cnt == 4'd15);
    assign io_bus.in_ready  = (r_state == IDLE) && rst;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_state = r_out_state;
    assign io_bus.out_error = r_out_error;
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_sreg      <= 16'd0;
            r_cnt       <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_state <= 4'd0;
            r_out_error <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_sreg      <= w_sreg;
            r_cnt       <= w_cnt;
            r_out_valid <= w_out_valid;
            r_out_state <= w_out_state;
            r_out_error <= w_out_error;
        end
    end
    always_comb begin
        w_next      = r_state;
        w_sreg      = r_sreg;
        w_cnt       = r_cnt;
        w_out_valid = r_out_valid;
        w_out_state = r_out_state;
        w_out_error = r_out_error;
        case (r_state)
            IDLE: if (io_bus.in_valid) begin
                if (io_bus.in_value == 16'd0) begin
                    w_next      = DONE;
                    w_out_valid = 1'b1;
                    w_out_state = 4'd0;
                    w_out_error = 1'b0;
                end else begin
                    w_next = SCAN;
                    w_sreg = io_bus.in_value;
                    w_cnt  = 4'd0;
                end
            end
            SCAN: if (r_sreg[0]) begin
                w_next      = DONE;
                w_out_valid = 1'b1;
                w_out_error = w_reject;
                w_out_state = w_reject ? 4'd0 : r_cnt;
            end else begin
                w_sreg = r_sreg >> 1;
                w_cnt  = r_cnt + 4'd1;
            end
            DONE: if (io_bus.out_ready) begin
                w_next      = IDLE;
                w_out_valid = 1'b0;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule
